trim_sweep_ctrl: RTL and testbench



---
 rtl/trim_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_trim_sweep_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/trim_sweep_ctrl.sv
// Bandgap trim sweep sequencer: shifts each code out serially, settles, samples CMP, stops on first hit.
// Optional macro TRIM_CMP_SYNC_EN adds a 2-flop synchronizer on CMP ahead of the sample point.
module trim_sweep_ctrl #(
  parameter int WIDTH      = 12,
  parameter int BIT_DIV    = 25,
  parameter int SETTLE_CYC = 1000,
  parameter int CODE_START = 0,
  parameter int CODE_END   = 4095
) (
  input  logic             CLK50,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             CMP,
  output logic             DOUT,
  output logic             ENCLK,
  output logic             BUSY,
  output logic             DONE,
  output logic             FOUND,
  output logic [WIDTH-1:0] TRIM_CODE,
  output logic [WIDTH-1:0] BEST_CODE
);

  localparam int DIV_W = $clog2(BIT_DIV);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BIT_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_MID    = DIV_W'(BIT_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [SET_W-1:0] SET_LAST   = SET_W'(SETTLE_CYC - 1);
  localparam logic [WIDTH-1:0] CODE_FIRST = WIDTH'(CODE_START);
  localparam logic [WIDTH-1:0] CODE_LAST  = WIDTH'(CODE_END);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SETTLE, SAMPLE, FINISH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [DIV_W-1:0] div_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic [SET_W-1:0] settle_cnt;
  logic             cmp_eff;
  logic             abort_act;

  assign abort_act = ABORT && (state != IDLE);

`ifdef TRIM_CMP_SYNC_EN
  logic cmp_s1, cmp_s2;
  always_ff @(posedge CLK50) begin
    if (RST) begin
      cmp_s1 <= 1'b0;
      cmp_s2 <= 1'b0;
    end else begin
      cmp_s1 <= CMP;
      cmp_s2 <= cmp_s1;
    end
  end
  assign cmp_eff = cmp_s2;
`else
  assign cmp_eff = CMP;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (div_cnt == DIV_LAST && bit_idx == BIT_LAST) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SET_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (cmp_eff || TRIM_CODE == CODE_LAST) ? FINISH : LOAD;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort_act) state_nxt = IDLE;
  end

  // Strobe and done are suppressed in the abort cycle so the chain never sees a partial event.
  assign BUSY  = (state != IDLE);
  assign DONE  = (state == FINISH) && !abort_act;
  assign ENCLK = (state == SHIFT) && (div_cnt == DIV_MID) && !abort_act;

  always_ff @(posedge CLK50) begin
    if (RST) begin
      state      <= IDLE;
      DOUT       <= 1'b0;
      FOUND      <= 1'b0;
      TRIM_CODE  <= '0;
      BEST_CODE  <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (abort_act) begin
        DOUT <= 1'b0;
      end else begin
        case (state)
          IDLE: if (START) begin
            TRIM_CODE <= CODE_FIRST;
            FOUND     <= 1'b0;
          end
          LOAD: begin
            shreg   <= TRIM_CODE;
            bit_idx <= '0;
            div_cnt <= '0;
          end
          SHIFT: begin
            if (div_cnt == '0) DOUT <= shreg[0];
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == BIT_LAST) begin
                DOUT       <= 1'b0;
                settle_cnt <= '0;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          SETTLE: settle_cnt <= settle_cnt + 1'b1;
          SAMPLE: begin
            if (cmp_eff) begin
              FOUND     <= 1'b1;
              BEST_CODE <= TRIM_CODE;
            end else if (TRIM_CODE == CODE_LAST) begin
              FOUND     <= 1'b0;
              BEST_CODE <= CODE_LAST;
            end else begin
              TRIM_CODE <= TRIM_CODE + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trim_sweep_ctrl.sv
// Directed bench for trim_sweep_ctrl with BIT_DIV=4, SETTLE_CYC=8, codes 0..7 (58 cycles per code).
module tb_trim_sweep_ctrl;

  logic        CLK50 = 1'b0;
  logic        RST, START, ABORT, CMP;
  logic        DOUT, ENCLK, BUSY, DONE, FOUND;
  logic [11:0] TRIM_CODE, BEST_CODE;

  int checks = 0;
  int errors = 0;

  trim_sweep_ctrl #(
    .WIDTH(12), .BIT_DIV(4), .SETTLE_CYC(8), .CODE_START(0), .CODE_END(7)
  ) dut (
    .CLK50(CLK50), .RST(RST), .START(START), .ABORT(ABORT), .CMP(CMP),
    .DOUT(DOUT), .ENCLK(ENCLK), .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND),
    .TRIM_CODE(TRIM_CODE), .BEST_CODE(BEST_CODE)
  );

  always #10 CLK50 = ~CLK50;

  typedef struct {
    int hit;        // code at which CMP is driven high, -1 for never
    int cmp_from;   // CMP window within that code, cycles after LOAD
    int cmp_to;
    int exp_found;
    int exp_best;
    int exp_enclk;
    int exp_cycles; // BUSY cycles including FINISH
    int ser_chk;
  } vec_t;

  vec_t vecs[6];
  vec_t restart_v;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50);
    #1;
  endtask

  task automatic run_sweep(input vec_t v, input int idx);
    int n;
    int c;
    int enclk_cnt = 0;
    int done_cnt  = 0;
    int phase_err = 0;
    int sbit      = 0;
    bit [11:0] ser = '0;
    START = 1'b1;
    tick();
    START = 1'b0;
    check($sformatf("v%0d_start_code", idx), int'(TRIM_CODE), 0);
    for (n = 0; n < 2000; n++) begin
      if (!BUSY) break;
      c = n % 58;
      CMP = (v.hit >= 0) && (int'(TRIM_CODE) == v.hit) && (c >= v.cmp_from) && (c <= v.cmp_to);
      if (ENCLK) begin
        enclk_cnt++;
        if (c < 3 || c > 47 || ((c - 3) % 4) != 0) phase_err++;
        if (TRIM_CODE == 12'd5 && sbit < 12) begin
          ser[sbit] = DOUT;
          sbit++;
        end
      end
      if (DONE) done_cnt++;
      tick();
    end
    CMP = 1'b0;
    check($sformatf("v%0d_cycles", idx), n, v.exp_cycles);
    check($sformatf("v%0d_done_pulses", idx), done_cnt, 1);
    check($sformatf("v%0d_enclk", idx), enclk_cnt, v.exp_enclk);
    check($sformatf("v%0d_enclk_phase", idx), phase_err, 0);
    check($sformatf("v%0d_found", idx), int'(FOUND), v.exp_found);
    check($sformatf("v%0d_best", idx), int'(BEST_CODE), v.exp_best);
    check($sformatf("v%0d_trim", idx), int'(TRIM_CODE), v.exp_best);
    if (v.ser_chk != 0) check($sformatf("v%0d_serial", idx), int'(ser), 32'h005);
  endtask

  initial begin
    vecs[0] = '{-1,  0, 57, 0, 7, 96, 465, 0};
    vecs[1] = '{ 0,  0, 57, 1, 0, 12,  59, 0};
    vecs[2] = '{ 7,  0, 57, 1, 7, 96, 465, 0};
`ifdef TRIM_CMP_SYNC_EN
    vecs[3] = '{ 3, 57, 57, 0, 7, 96, 465, 0};
`else
    vecs[3] = '{ 3, 57, 57, 1, 3, 48, 233, 0};
`endif
    vecs[4] = '{ 4, 55, 57, 1, 4, 60, 291, 0};
    vecs[5] = '{ 5,  0, 57, 1, 5, 72, 349, 1};
    restart_v = '{ 2, 0, 57, 1, 2, 36, 175, 0};

    RST = 1'b1; START = 1'b1; ABORT = 1'b0; CMP = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(BUSY), 0);
    check("rst_dout", int'(DOUT), 0);
    check("rst_enclk", int'(ENCLK), 0);
    check("rst_done", int'(DONE), 0);
    check("rst_found", int'(FOUND), 0);
    check("rst_trim", int'(TRIM_CODE), 0);
    check("rst_best", int'(BEST_CODE), 0);
    RST = 1'b0;
    tick();
    check("start_busy", int'(BUSY), 1);
    START = 1'b0;
    ABORT = 1'b1;
    tick();
    check("abort_from_load", int'(BUSY), 0);
    ABORT = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_sweep(vecs[i], i);
      tick();
    end

    // ABORT while idle is ignored
    ABORT = 1'b1;
    repeat (2) tick();
    check("idle_abort_busy", int'(BUSY), 0);
    check("idle_abort_found", int'(FOUND), 1);
    check("idle_abort_best", int'(BEST_CODE), 5);
    ABORT = 1'b0;

    // Abort in the middle of code 3's second bit, on its strobe cycle
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 400 && TRIM_CODE != 12'd3; i++) tick();
    check("reach_code3", int'(TRIM_CODE), 3);
    repeat (7) tick();
    check("pre_abort_dout", int'(DOUT), 1);
    check("pre_abort_enclk", int'(ENCLK), 1);
    ABORT = 1'b1;
    #1;
    check("abort_enclk_gated", int'(ENCLK), 0);
    tick();
    ABORT = 1'b0;
    check("abort_busy", int'(BUSY), 0);
    check("abort_dout", int'(DOUT), 0);
    check("abort_done", int'(DONE), 0);
    check("abort_found", int'(FOUND), 0);
    check("abort_best", int'(BEST_CODE), 5);
    begin
      int dn = 0;
      for (int i = 0; i < 5; i++) begin
        if (DONE || BUSY) dn++;
        tick();
      end
      check("abort_quiet", dn, 0);
    end

    run_sweep(restart_v, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
